// File: rtl/sr_target.sv
// Device-side model of the serial shift-register link: oversamples clk_sr/din_sr/load_sr,
// captures a WIDTH-bit config word on load and shifts a parallel status word back out.
module sr_target #(
    parameter int WIDTH = 170,
    parameter int SYNC  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_sr,
    input  logic                       din_sr,
    input  logic                       load_sr,
    input  logic [WIDTH-1:0]           status_in,
    output logic                       dout_sr,
    output logic [WIDTH-1:0]           cfg_out,
    output logic                       cfg_valid,
    output logic                       len_err,
    output logic [$clog2(WIDTH+2)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    logic [SYNC-1:0]  clk_pipe;
    logic [SYNC-1:0]  din_pipe;
    logic [SYNC-1:0]  ld_pipe;
    logic             clk_d;
    logic             ld_d;
    logic             din_sync;
    logic             sr_rise;
    logic             sr_fall;
    logic             ld_rise;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt_shifted;

    // Events are registered; din_sync is taken from the same synchronizer stage as
    // the clk_sr sample that produced sr_rise, so data and strobe stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_pipe <= '0;
            din_pipe <= '0;
            ld_pipe  <= '0;
            clk_d    <= 1'b0;
            ld_d     <= 1'b0;
            din_sync <= 1'b0;
            sr_rise  <= 1'b0;
            sr_fall  <= 1'b0;
            ld_rise  <= 1'b0;
        end else begin
            clk_pipe <= {clk_pipe[SYNC-2:0], clk_sr};
            din_pipe <= {din_pipe[SYNC-2:0], din_sr};
            ld_pipe  <= {ld_pipe[SYNC-2:0], load_sr};
            clk_d    <= clk_pipe[SYNC-1];
            ld_d     <= ld_pipe[SYNC-1];
            din_sync <= din_pipe[SYNC-1];
            sr_rise  <= clk_pipe[SYNC-1] & ~clk_d;
            sr_fall  <= ~clk_pipe[SYNC-1] & clk_d;
            ld_rise  <= ld_pipe[SYNC-1] & ~ld_d;
        end
    end

    // Post-shift view, so a load coinciding with a rising edge counts that bit.
    always_comb begin
        shreg_shifted = shreg;
        cnt_shifted   = bit_cnt;
        if (sr_rise) begin
            shreg_shifted = {shreg[WIDTH-2:0], din_sync};
            if (bit_cnt != CNT_SAT) begin
                cnt_shifted = bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            cfg_out   <= '0;
            dout_sr   <= 1'b0;
            cfg_valid <= 1'b0;
            len_err   <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            cfg_valid <= 1'b0;
            len_err   <= 1'b0;
            shreg     <= shreg_shifted;
            bit_cnt   <= cnt_shifted;
            if (sr_fall) begin
                dout_sr <= shreg[WIDTH-1];
            end
            if (ld_rise) begin
                if (cnt_shifted == CNT_FULL) begin
                    cfg_out   <= shreg_shifted;
                    cfg_valid <= 1'b1;
                end else begin
                    len_err <= 1'b1;
                end
                shreg   <= status_in;
                dout_sr <= status_in[WIDTH-1];
                bit_cnt <= '0;
            end
        end
    end

endmodule
